// File: rtl/multdiv_pkg.sv
// Shared types and sizing helpers for the iterative multiply/divide unit.
package multdiv_pkg;

    localparam int unsigned DefaultWidth = 32;

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StDiv,
        StDone
    } state_e;

    typedef enum logic {
        OpMul,
        OpDiv
    } op_e;

    // Iteration counter must hold WIDTH-1 with headroom.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/multdiv_addsub.sv
// WIDTH+1-bit adder/subtractor with carry-out, shared by multiply accumulate and divide trial.
module multdiv_addsub
    import multdiv_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic [WIDTH:0] a,
    input  logic [WIDTH:0] b,
    input  logic           sub,
    output logic [WIDTH:0] sum,
    output logic           carry
);

    // On subtract, carry=1 means a >= b (no borrow).
    assign {carry, sum} = {1'b0, a} + {1'b0, b ^ {(WIDTH + 1){sub}}}
                        + {{(WIDTH + 1){1'b0}}, sub};

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed multiply (shift-add) / divide (restoring), one bit per cycle on magnitudes.
module multdiv_unit
    import multdiv_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             data_busy
);

    localparam int unsigned CntW  = cnt_width(WIDTH);
    localparam int unsigned ProdW = 2 * WIDTH;

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [CntW-1:0]  count_q, count_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic             neg_q, neg_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             exc_q, exc_d;
    logic             rdy_q, rdy_d;

    logic             start;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   as_a, as_b, as_sum;
    logic             as_sub, as_carry;
    logic [ProdW-1:0] prod_mag, prod;
    logic [WIDTH-1:0] quot;

    assign start = ctrl_MULT | ctrl_DIV;
    assign mag_a = data_operandA[WIDTH-1] ? (~data_operandA + WIDTH'(1)) : data_operandA;
    assign mag_b = data_operandB[WIDTH-1] ? (~data_operandB + WIDTH'(1)) : data_operandB;

    // Multiply: {acc,lo} is the running product. Divide: acc is remainder, lo shifts
    // dividend bits out and quotient bits in.
    assign prod_mag = {acc_q, lo_q};
    assign prod     = neg_q ? (~prod_mag + ProdW'(1)) : prod_mag;
    assign quot     = neg_q ? (~lo_q + WIDTH'(1)) : lo_q;

    always_comb begin
        if (state_q == StDiv) begin
            as_a   = {acc_q, lo_q[WIDTH-1]};
            as_b   = {1'b0, opb_q};
            as_sub = 1'b1;
        end else begin
            as_a   = {1'b0, acc_q};
            as_b   = lo_q[0] ? {1'b0, opb_q} : '0;
            as_sub = 1'b0;
        end
    end

    multdiv_addsub #(
        .WIDTH (WIDTH)
    ) u_addsub (
        .a     (as_a),
        .b     (as_b),
        .sub   (as_sub),
        .sum   (as_sum),
        .carry (as_carry)
    );

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        count_d  = count_q;
        acc_d    = acc_q;
        lo_d     = lo_q;
        opb_d    = opb_q;
        neg_d    = neg_q;
        result_d = result_q;
        exc_d    = exc_q;
        rdy_d    = 1'b0;

        // A start always wins, aborting whatever is in flight.
        if (start) begin
            state_d = ctrl_MULT ? StMul : StDiv;
            op_d    = ctrl_MULT ? OpMul : OpDiv;
            count_d = '0;
            acc_d   = '0;
            lo_d    = ctrl_MULT ? mag_b : mag_a;
            opb_d   = ctrl_MULT ? mag_a : mag_b;
            neg_d   = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        end else begin
            unique case (state_q)
                StMul: begin
                    acc_d   = as_sum[WIDTH:1];
                    lo_d    = {as_sum[0], lo_q[WIDTH-1:1]};
                    count_d = count_q + CntW'(1);
                    if (count_q == CntW'(WIDTH - 1)) state_d = StDone;
                end
                StDiv: begin
                    if (opb_q == '0) begin
                        result_d = '0;
                        exc_d    = 1'b1;
                        rdy_d    = 1'b1;
                        state_d  = StIdle;
                    end else begin
                        acc_d   = as_carry ? as_sum[WIDTH-1:0] : as_a[WIDTH-1:0];
                        lo_d    = {lo_q[WIDTH-2:0], as_carry};
                        count_d = count_q + CntW'(1);
                        if (count_q == CntW'(WIDTH - 1)) state_d = StDone;
                    end
                end
                StDone: begin
                    state_d = StIdle;
                    rdy_d   = 1'b1;
                    if (op_q == OpMul) begin
                        result_d = prod[WIDTH-1:0];
                        exc_d    = ~((&prod[ProdW-1:WIDTH-1]) | ~(|prod[ProdW-1:WIDTH-1]));
                    end else begin
                        result_d = quot;
                        // Only MIN_INT / -1 yields a positive quotient magnitude of 2^(WIDTH-1).
                        exc_d    = ~neg_q & lo_q[WIDTH-1];
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            op_q     <= OpMul;
            count_q  <= '0;
            acc_q    <= '0;
            lo_q     <= '0;
            opb_q    <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            lo_q     <= lo_d;
            opb_q    <= opb_d;
            neg_q    <= neg_d;
            result_q <= result_d;
            exc_q    <= exc_d;
            rdy_q    <= rdy_d;
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;
    assign data_busy      = (state_q != StIdle);

endmodule
